// File: rtl/ldst_mem_responder_if.sv
// ldst_mem_responder_if: load-queue and store-queue handshake bundle between agent and memory responder
interface ldst_mem_responder_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 7
);
    logic                  ldq_addr_valid;
    logic [ID_WIDTH-1:0]   ldq_id;
    logic                  ldq_addr_ready;
    logic                  ldq_data_valid;
    logic [DATA_WIDTH-1:0] ldq_data;
    logic                  ldq_data_ready;
    logic                  stq_valid;
    logic [DATA_WIDTH-1:0] stq_data;
    logic                  stq_ready;
    logic [31:0]           st_count;
    logic [31:0]           st_csum;
    modport master (
        output ldq_addr_valid, ldq_id, ldq_data_ready, stq_valid, stq_data,
        input  ldq_addr_ready, ldq_data_valid, ldq_data, stq_ready, st_count, st_csum
    );
    modport slave (
        input  ldq_addr_valid, ldq_id, ldq_data_ready, stq_valid, stq_data,
        output ldq_addr_ready, ldq_data_valid, ldq_data, stq_ready, st_count, st_csum
    );
endinterface

// File: rtl/ldst_mem_responder.sv
// ldst_mem_responder: in-order load responder with id-derived data plus store sink with count/XOR checksum
// Optional LFSR-driven ready throttling under LDST_RESP_BACKPRESSURE_EN.
module ldst_mem_responder #(
    parameter int          DATA_WIDTH   = 512,
    parameter int          ID_WIDTH     = 7,
    parameter int          DEPTH        = 4,
    parameter int          LATENCY      = 2,
    parameter logic [31:0] PATTERN_SEED = 32'h0
) (
    input logic clk,
    input logic rstn,
    ldst_mem_responder_if.slave bus
);
    localparam int LANES = DATA_WIDTH / 32;
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);
    logic [LATENCY-1:0]  pv;
    logic [ID_WIDTH-1:0] pid [LATENCY];
    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wp, rp;
    logic [OW-1:0]       outst, fcnt;
    logic                acc, hs, wr, st_acc;
    logic [31:0]         fold;
    assign wr     = pv[LATENCY-1];
    assign acc    = bus.ldq_addr_valid & bus.ldq_addr_ready;
    assign hs     = bus.ldq_data_valid & bus.ldq_data_ready;
    assign st_acc = bus.stq_valid & bus.stq_ready;
    assign bus.ldq_data_valid = fcnt != '0;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pv            <= '0;
            outst         <= '0;
            fcnt          <= '0;
            wp            <= '0;
            rp            <= '0;
            bus.st_count  <= '0;
            bus.st_csum   <= '0;
        end else begin
            pv[0] <= acc;
            for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
            outst <= outst + OW'(acc) - OW'(hs);
            fcnt  <= fcnt + OW'(wr) - OW'(hs);
            wp    <= wp + AW'(wr);
            rp    <= rp + AW'(hs);
            if (st_acc) begin
                bus.st_count <= bus.st_count + 32'd1;
                bus.st_csum  <= bus.st_csum ^ fold;
            end
        end
    end
    // id payload carries no reset; only the valid bits and pointers qualify it
    always_ff @(posedge clk) begin
        pid[0] <= bus.ldq_id;
        for (int i = 1; i < LATENCY; i++) pid[i] <= pid[i-1];
        if (wr) mem[wp] <= pid[LATENCY-1];
    end
    always_comb begin
        bus.ldq_data = '0;
        fold = '0;
        for (int k = 0; k < LANES; k++) begin
            bus.ldq_data[32*k +: 32] = bus.ldq_data_valid ?
                ({{(16-ID_WIDTH){1'b0}}, mem[rp], 16'(k)} ^ PATTERN_SEED) : 32'h0;
            fold ^= bus.stq_data[32*k +: 32];
        end
    end
`ifdef LDST_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic        st_rdy;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr   <= 16'hACE1;
            st_rdy <= 1'b1;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            st_rdy <= ~lfsr[1];
        end
    end
    assign bus.ldq_addr_ready = (outst != OW'(DEPTH)) & ~lfsr[0];
    assign bus.stq_ready      = st_rdy;
`else
    assign bus.ldq_addr_ready = outst != OW'(DEPTH);
    assign bus.stq_ready      = 1'b1;
`endif
endmodule
